load_store_unit: RTL and testbench

Load/store unit between the RV32I core's memory stage and the word-addressed byte-masked `memory` block. Accepts one load or store per request, drives the memory port (`mem_addr`, `mem_rstrb`, `mem_wdata`, `mem_wmask`) with aligned word address, replicated write data and byte-lane mask, then extracts and sign/zero-extends load data from `mem_rdata`. Flags misaligned or illegal accesses without touching memory.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/load_align.sv | 40 ++++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 width codes,
// LSU state encoding and the request legality check.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Unknown width codes, unsigned stores and misaligned halfword/word accesses are rejected.
  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B, F3_BU:  err = 1'b0;
      F3_H, F3_HU:  err = offset[0];
      F3_W:         err = (offset != 2'b00);
      default:      err = 1'b1;
    endcase
    if (we && funct3[2]) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of the memory
// word and sign- or zero-extends it to 32 bits.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  assign lane = mem_rdata >> {offset, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = sext8(lane[7:0]);
      F3_H:    load_data = sext16(lane[15:0]);
      F3_BU:   load_data = {24'h0, lane[7:0]};
      F3_HU:   load_data = {16'h0, lane[15:0]};
      F3_W:    load_data = lane;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request, runs a single memory cycle on the
// byte-masked word port and returns extended load data two cycles after accept.
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nxt;
  logic        accept;

  logic [31:2] addr_p1;
  logic [1:0]  offset_p1;
  logic        we_p1;
  logic [2:0]  funct3_p1;
  logic [31:0] wdata_p1;
  logic        err_p1;

  logic        in_mem, in_resp;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] load_data;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_ready && req_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_MEM;
      ST_MEM:  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: request captured on the accept edge; data registers carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1   <= req_addr[31:2];
      offset_p1 <= req_addr[1:0];
      we_p1     <= req_we;
      funct3_p1 <= req_funct3;
      wdata_p1  <= req_wdata;
      err_p1    <= req_error(req_we, req_funct3, req_addr[1:0]);
    end
  end

  assign in_mem  = (state == ST_MEM)  && !reset;
  assign in_resp = (state == ST_RESP) && !reset;

  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (funct3_p1)
      F3_B: begin
        st_mask = 4'b0001 << offset_p1;
        st_data = {4{wdata_p1[7:0]}};
      end
      F3_H: begin
        st_mask = 4'b0011 << offset_p1;
        st_data = {2{wdata_p1[15:0]}};
      end
      F3_W: begin
        st_mask = 4'b1111;
        st_data = wdata_p1;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Stage p2: memory cycle, access only when the request is legal and reset is low
  assign mem_addr  = in_mem ? {addr_p1, 2'b00} : 32'h0;
  assign mem_rstrb = in_mem && !we_p1 && !err_p1;
  assign mem_wmask = (in_mem && we_p1 && !err_p1) ? st_mask : 4'b0000;
  assign mem_wdata = (in_mem && we_p1 && !err_p1) ? st_data : 32'h0;

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .offset    (offset_p1),
    .funct3    (funct3_p1),
    .load_data (load_data)
  );

  // Stage p3: response pulse with read data arriving from memory this cycle
  assign rsp_valid = in_resp;
  assign rsp_error = in_resp && err_p1;
  assign rsp_rdata = (in_resp && !we_p1 && !err_p1) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-masked word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[11:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request; returns what the memory port and response showed in each cycle.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input string tag,
                      output logic [31:0] m_addr, output logic [31:0] m_wdata,
                      output logic [3:0] m_wmask, output logic m_rstrb,
                      output logic v1, output logic v2,
                      output logic [31:0] rdata, output logic err);
    @(negedge clk);
    check_eq({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hffff_ffff; req_wdata = 32'h5555_5555;
    @(negedge clk);
    m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
    m_rstrb = mem_rstrb; v1 = rsp_valid;
    @(negedge clk);
    v2 = rsp_valid; rdata = rsp_rdata; err = rsp_error;
  endtask

  logic [31:0] m_addr, m_wdata, rdata;
  logic [3:0]  m_wmask;
  logic        m_rstrb, v1, v2, err;

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp, input string tag);
    xact(1'b0, f3, addr, 32'h0, tag, m_addr, m_wdata, m_wmask, m_rstrb, v1, v2, rdata, err);
    check_eq({tag, " mem_addr"}, m_addr, {addr[31:2], 2'b00});
    check_eq({tag, " rstrb"}, {31'h0, m_rstrb}, 32'h1);
    check_eq({tag, " early_vld"}, {31'h0, v1}, 32'h0);
    check_eq({tag, " rsp_valid"}, {31'h0, v2}, 32'h1);
    check_eq({tag, " rdata"}, rdata, exp);
    check_eq({tag, " error"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, pulses;
    int pcyc [3];

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[100] = 32'h0403_0201;
    mem[103] = 32'hff0f_0e0d;
    mem_rdata = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check_eq("rst ready", {31'h0, req_ready}, 32'h0);
    check_eq("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst rsp_error", {31'h0, rsp_error}, 32'h0);
    check_eq("rst mem_addr", mem_addr, 32'h0);
    check_eq("rst mem_wdata", mem_wdata, 32'h0);
    check_eq("rst mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
    check_eq("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
    reset = 1'b0;

    do_load(3'b010, 32'd400, 32'h0403_0201, "LW400");
    do_load(3'b000, 32'd415, 32'hffff_ffff, "LB415");
    do_load(3'b100, 32'd415, 32'h0000_00ff, "LBU415");
    do_load(3'b001, 32'd414, 32'hffff_ff0f, "LH414");

    xact(1'b1, 3'b001, 32'd802, 32'h1234_abcd, "SH802",
         m_addr, m_wdata, m_wmask, m_rstrb, v1, v2, rdata, err);
    check_eq("SH802 mem_addr", m_addr, 32'd800);
    check_eq("SH802 wmask", {28'h0, m_wmask}, 32'hc);
    check_eq("SH802 wdata", m_wdata, 32'habcd_abcd);
    check_eq("SH802 rstrb", {31'h0, m_rstrb}, 32'h0);
    check_eq("SH802 rsp_valid", {31'h0, v2}, 32'h1);
    check_eq("SH802 rdata", rdata, 32'h0);
    check_eq("SH802 error", {31'h0, err}, 32'h0);

    do_load(3'b101, 32'd802, 32'h0000_abcd, "LHU802");
    do_load(3'b010, 32'd800, 32'habcd_0000, "LW800");

    xact(1'b0, 3'b010, 32'd401, 32'h0, "LW401",
         m_addr, m_wdata, m_wmask, m_rstrb, v1, v2, rdata, err);
    check_eq("LW401 rstrb", {31'h0, m_rstrb}, 32'h0);
    check_eq("LW401 wmask", {28'h0, m_wmask}, 32'h0);
    check_eq("LW401 early_vld", {31'h0, v1}, 32'h0);
    check_eq("LW401 rsp_valid", {31'h0, v2}, 32'h1);
    check_eq("LW401 error", {31'h0, err}, 32'h1);
    check_eq("LW401 rdata", rdata, 32'h0);

    xact(1'b1, 3'b100, 32'd800, 32'h0000_0077, "SBU800",
         m_addr, m_wdata, m_wmask, m_rstrb, v1, v2, rdata, err);
    check_eq("SBU800 rstrb", {31'h0, m_rstrb}, 32'h0);
    check_eq("SBU800 wmask", {28'h0, m_wmask}, 32'h0);
    check_eq("SBU800 rsp_valid", {31'h0, v2}, 32'h1);
    check_eq("SBU800 error", {31'h0, err}, 32'h1);
    check_eq("SBU800 rdata", rdata, 32'h0);
    do_load(3'b010, 32'd800, 32'habcd_0000, "LW800b");

    // Store aborted by reset during its memory cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'd800; req_wdata = 32'hdead_beef;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("SWrst wmask", {28'h0, mem_wmask}, 32'h0);
    check_eq("SWrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("SWrst ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("SWrst ready_after", {31'h0, req_ready}, 32'h1);
    check_eq("SWrst no_rsp", {31'h0, rsp_valid}, 32'h0);
    do_load(3'b010, 32'd800, 32'habcd_0000, "LW800c");

    // req_valid held for nine cycles
    acc = 0; pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd400;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready && req_valid) acc++;
      if (rsp_valid) begin
        if (pulses < 3) pcyc[pulses] = i;
        pulses++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("held accepts", acc, 32'd3);
    check_eq("held pulses", pulses, 32'd3);
    check_eq("held first_pulse", pcyc[0], 32'd2);
    check_eq("held spacing1", pcyc[1] - pcyc[0], 32'd3);
    check_eq("held spacing2", pcyc[2] - pcyc[1], 32'd3);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
